// File: rtl/z16_mem_arbiter.sv
// Two-master (CPU / loader) arbiter for a single-port data memory, with bounded bursts per grant.
// Build option: define Z16_ARB_ROUND_ROBIN_EN to break IDLE ties in favour of the master not served last.
module z16_mem_arbiter #(
  parameter int unsigned P_MAX_BURST = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_wen,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_wdata,
  input  logic        i_m1_req,
  input  logic        i_m1_wen,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_wdata,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m1_rvalid,
  output logic [15:0] o_m0_rdata,
  output logic [15:0] o_m1_rdata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata
);

  localparam logic [3:0] MAX_BEATS = 4'(P_MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state;
  logic        gnt0_q;
  logic        gnt1_q;
  logic [3:0]  beat_cnt;
  logic        m0_rvalid_q;
  logic        m1_rvalid_q;
  logic [15:0] m0_rdata_q;
  logic [15:0] m1_rdata_q;

  logic        m0_beat;
  logic        m1_beat;
  logic [3:0]  cnt_next;
  logic        burst_done;
  logic        idle_pick_m1;

  // Reset masks every output immediately, so a read accepted just before reset never reports.
  assign o_m0_gnt    = gnt0_q & ~i_rst;
  assign o_m1_gnt    = gnt1_q & ~i_rst;
  assign o_m0_rvalid = m0_rvalid_q & ~i_rst;
  assign o_m1_rvalid = m1_rvalid_q & ~i_rst;
  assign o_m0_rdata  = i_rst ? '0 : m0_rdata_q;
  assign o_m1_rdata  = i_rst ? '0 : m1_rdata_q;

  assign m0_beat = i_m0_req & o_m0_gnt;
  assign m1_beat = i_m1_req & o_m1_gnt;

  // Beats served by the current owner including this cycle's, saturating at the burst limit.
  assign cnt_next   = ((m0_beat | m1_beat) && (beat_cnt < MAX_BEATS)) ? beat_cnt + 4'd1 : beat_cnt;
  assign burst_done = (cnt_next >= MAX_BEATS);

`ifdef Z16_ARB_ROUND_ROBIN_EN
  logic last_m1;
  assign idle_pick_m1 = i_m1_req & (~i_m0_req | ~last_m1);
`else
  assign idle_pick_m1 = i_m1_req & ~i_m0_req;
`endif

  always_comb begin
    // NOTE: every output gets a default before the branches; a missing default infers a latch.
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    if (m0_beat) begin
      o_mem_addr  = i_m0_addr;
      o_mem_wen   = i_m0_wen;
      o_mem_wdata = i_m0_wdata;
    end else if (m1_beat) begin
      o_mem_addr  = i_m1_addr;
      o_mem_wen   = i_m1_wen;
      o_mem_wdata = i_m1_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state    <= IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      beat_cnt <= '0;
`ifdef Z16_ARB_ROUND_ROBIN_EN
      last_m1  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (idle_pick_m1) begin
            state  <= GNT1;
            gnt1_q <= 1'b1;
`ifdef Z16_ARB_ROUND_ROBIN_EN
            last_m1 <= 1'b1;
`endif
          end else if (i_m0_req) begin
            state  <= GNT0;
            gnt0_q <= 1'b1;
`ifdef Z16_ARB_ROUND_ROBIN_EN
            last_m1 <= 1'b0;
`endif
          end
        end
        GNT0: begin
          if (!i_m0_req || (burst_done && i_m1_req)) begin
            gnt0_q   <= 1'b0;
            beat_cnt <= '0;
            if (i_m1_req) begin
              state  <= GNT1;
              gnt1_q <= 1'b1;
`ifdef Z16_ARB_ROUND_ROBIN_EN
              last_m1 <= 1'b1;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            beat_cnt <= cnt_next;
          end
        end
        GNT1: begin
          if (!i_m1_req || (burst_done && i_m0_req)) begin
            gnt1_q   <= 1'b0;
            beat_cnt <= '0;
            if (i_m0_req) begin
              state  <= GNT0;
              gnt0_q <= 1'b1;
`ifdef Z16_ARB_ROUND_ROBIN_EN
              last_m1 <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            beat_cnt <= cnt_next;
          end
        end
        default: begin
          state    <= IDLE;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Read data returns one cycle after the accepted beat and is held until that master reads again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_beat & ~i_m0_wen;
      m1_rvalid_q <= m1_beat & ~i_m1_wen;
      if (m0_beat && !i_m0_wen) m0_rdata_q <= i_mem_rdata;
      if (m1_beat && !i_m1_wen) m1_rdata_q <= i_mem_rdata;
    end
  end

  grants_exclusive: assert property (@(posedge i_clk) !(o_m0_gnt && o_m1_gnt));

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Randomized bench for z16_mem_arbiter against a transaction-level ownership/memory model,
// plus directed scenarios with hand-computed expectations.
module tb_z16_mem_arbiter;

  localparam int P = 8;
`ifdef Z16_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [15:0] addr;
    logic [15:0] wdata;
  } port_t;

  localparam port_t NONE = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_wen = 1'b0, m1_req = 1'b0, m1_wen = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wen;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  z16_mem_arbiter #(.P_MAX_BURST(P)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_wen(m0_wen), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_wen(m1_wen), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt),
    .o_m0_rvalid(m0_rvalid), .o_m1_rvalid(m1_rvalid),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Environment memory: combinational read, write on the clock edge.
  logic [15:0] mem [256];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_wen) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory (-1 = nobody), how many beats it has used, who was served last,
  // pending read returns and a shadow copy of memory contents.
  int          owner = -1;
  int          beats = 0;
  int          last  = 1;
  bit          pend_rv [2];
  logic [15:0] pend_rd [2];
  logic [15:0] shadow  [256];

  bit          e_gnt [2];
  bit          e_rv  [2];
  logic [15:0] e_rd  [2];
  bit          e_wen;
  logic [15:0] e_addr, e_wdata;
  bit          checking = 1'b0;

  task automatic grant(input int x);
    owner = x;
    beats = 0;
    last  = x;
  endtask

  // One clock cycle: drive inputs after the edge, derive expectations, advance the model.
  task automatic step(input bit r, input port_t p0, input port_t p1);
    port_t p [2];
    bit    beat [2];
    int    me, other, served;
    @(posedge clk);
    #1;
    p[0] = p0;
    p[1] = p1;
    rst = r;
    m0_req = p0.req; m0_wen = p0.wen; m0_addr = p0.addr; m0_wdata = p0.wdata;
    m1_req = p1.req; m1_wen = p1.wen; m1_addr = p1.addr; m1_wdata = p1.wdata;
    e_wen = 1'b0; e_addr = '0; e_wdata = '0;
    for (int x = 0; x < 2; x++) begin
      e_gnt[x] = !r && (owner == x);
      beat[x]  = e_gnt[x] && p[x].req;
      e_rv[x]  = !r && pend_rv[x];
      e_rd[x]  = r ? 16'h0 : pend_rd[x];
      if (beat[x]) begin
        e_wen   = p[x].wen;
        e_addr  = p[x].addr;
        e_wdata = p[x].wdata;
      end
    end
    if (r) begin
      owner = -1; beats = 0; last = 1;
      for (int x = 0; x < 2; x++) begin
        pend_rv[x] = 1'b0;
        pend_rd[x] = '0;
      end
    end else begin
      for (int x = 0; x < 2; x++) begin
        pend_rv[x] = beat[x] && !p[x].wen;
        if (pend_rv[x]) pend_rd[x] = shadow[p[x].addr[7:0]];
        if (beat[x] && p[x].wen) shadow[p[x].addr[7:0]] = p[x].wdata;
      end
      if (owner < 0) begin
        if (p[0].req && p[1].req) grant(RR ? 1 - last : 0);
        else if (p[0].req)        grant(0);
        else if (p[1].req)        grant(1);
      end else begin
        me     = owner;
        other  = 1 - owner;
        served = beats + (beat[me] ? 1 : 0);
        if (served > P) served = P;
        if (!p[me].req) begin
          if (p[other].req) grant(other);
          else owner = -1;
        end else if (served == P && p[other].req) begin
          grant(other);
        end else begin
          beats = served;
        end
      end
    end
    checking = 1'b1;
    #3;
  endtask

  function automatic port_t rd(input logic [15:0] a);
    return '{req: 1'b1, wen: 1'b0, addr: a, wdata: 16'h0};
  endfunction

  function automatic port_t wr(input logic [15:0] a, input logic [15:0] d);
    return '{req: 1'b1, wen: 1'b1, addr: a, wdata: d};
  endfunction

  function automatic port_t rnd_port(input bit q);
    return '{req: q, wen: 1'($urandom_range(1)), addr: 16'($urandom), wdata: 16'($urandom)};
  endfunction

  // Compare process: every cycle against the model, plus mutual exclusion and grant latency.
  int wait_c [2];
  bit cmp_g, cmp_q;
  always @(negedge clk) begin
    if (checking) begin
      check("m0_gnt",    32'(m0_gnt),    32'(e_gnt[0]));
      check("m1_gnt",    32'(m1_gnt),    32'(e_gnt[1]));
      check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
      check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
      check("m0_rdata",  32'(m0_rdata),  32'(e_rd[0]));
      check("m1_rdata",  32'(m1_rdata),  32'(e_rd[1]));
      check("mem_wen",   32'(mem_wen),   32'(e_wen));
      check("mem_addr",  32'(mem_addr),  32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      check("gnt_exclusive", 32'(m0_gnt && m1_gnt), 32'd0);
      for (int x = 0; x < 2; x++) begin
        cmp_g = (x == 0) ? m0_gnt : m1_gnt;
        cmp_q = (x == 0) ? m0_req : m1_req;
        if (rst || !cmp_q) begin
          wait_c[x] = 0;
        end else if (cmp_g) begin
          if (wait_c[x] > 0) check("grant_latency_bound", 32'(wait_c[x] <= P + 2), 32'd1);
          wait_c[x] = 0;
        end else begin
          wait_c[x]++;
        end
      end
    end
  end

  int gseq [40];
  int cnt;
  bit got;
  bit q0, q1;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    // Reset with both masters requesting: every output must stay 0.
    repeat (3) step(1'b1, wr(16'h1234, 16'h5678), rd(16'h4321));
    check("rst_m0_gnt",    32'(m0_gnt),    32'd0);
    check("rst_m1_gnt",    32'(m1_gnt),    32'd0);
    check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("rst_mem_wen",   32'(mem_wen),   32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_m1_rdata",  32'(m1_rdata),  32'd0);
    step(1'b0, NONE, NONE);

    // m0 write then read-back of 0xBEEF at 0x0010.
    step(1'b0, wr(16'h0010, 16'hBEEF), NONE);
    step(1'b0, wr(16'h0010, 16'hBEEF), NONE);
    check("wr_m0_gnt",    32'(m0_gnt),    32'd1);
    check("wr_mem_wen",   32'(mem_wen),   32'd1);
    check("wr_mem_addr",  32'(mem_addr),  32'h0010);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    step(1'b0, rd(16'h0010), NONE);
    check("rd_mem_wen",   32'(mem_wen),   32'd0);
    check("rd_mem_addr",  32'(mem_addr),  32'h0010);
    step(1'b0, NONE, NONE);
    check("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("rd_m0_rdata",  32'(m0_rdata),  32'hBEEF);
    step(1'b0, NONE, NONE);
    check("rd_rvalid_pulse", 32'(m0_rvalid), 32'd0);
    check("rd_rdata_hold",   32'(m0_rdata),  32'hBEEF);

    // Both request continuously from reset: m0 first, then alternate every 8 beats.
    step(1'b1, NONE, NONE);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, rd(16'h0020), rd(16'h0030));
      gseq[c] = (m0_gnt ? 1 : 0) + (m1_gnt ? 2 : 0);
    end
    check("both_c0_none",     32'(gseq[0]),  32'd0);
    check("both_c1_m0",       32'(gseq[1]),  32'd1);
    check("both_c8_m0",       32'(gseq[8]),  32'd1);
    check("both_c9_m1",       32'(gseq[9]),  32'd2);
    check("both_c16_m1",      32'(gseq[16]), 32'd2);
    check("both_c17_m0",      32'(gseq[17]), 32'd1);
    check("both_c25_m1",      32'(gseq[25]), 32'd2);

    // m1 alone for 20 granted cycles: grant held; m0 then wins after one cycle (counter saturated).
    step(1'b1, NONE, NONE);
    step(1'b0, NONE, rd(16'h0040));
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, NONE, rd(16'h0040));
      if (m1_gnt) cnt++;
    end
    check("m1_hold_20", 32'(cnt), 32'd20);
    step(1'b0, rd(16'h0050), rd(16'h0040));
    check("sat_m1_still", 32'(m1_gnt), 32'd1);
    step(1'b0, rd(16'h0050), rd(16'h0040));
    check("sat_switch_m0", 32'(m0_gnt), 32'd1);

    // m0 arrives after two m1 beats: granted once m1 reaches 8 beats (6 cycles of waiting).
    step(1'b1, NONE, NONE);
    repeat (3) step(1'b0, NONE, rd(16'h0040));
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      step(1'b0, rd(16'h0050), rd(16'h0040));
      if (m0_gnt) got = 1'b1;
      else cnt++;
    end
    check("mid_burst_wait", 32'(cnt), 32'(P - 2));

    // Reset right after an accepted m1 read: no rvalid, outputs 0, FSM back in IDLE.
    step(1'b1, NONE, NONE);
    step(1'b0, NONE, rd(16'h0010));
    step(1'b0, NONE, rd(16'h0010));
    check("pre_rst_m1_gnt",  32'(m1_gnt),   32'd1);
    check("pre_rst_addr",    32'(mem_addr), 32'h0010);
    step(1'b1, NONE, rd(16'h0010));
    check("rst_rvalid_kill", 32'(m1_rvalid), 32'd0);
    check("rst_m1_rdata0",   32'(m1_rdata),  32'd0);
    check("rst_gnt0",        32'(m1_gnt),    32'd0);
    check("rst_addr0",       32'(mem_addr),  32'd0);
    step(1'b0, NONE, NONE);
    check("post_rst_idle0",  32'(m0_gnt),    32'd0);
    check("post_rst_idle1",  32'(m1_gnt),    32'd0);
    check("post_rst_rvalid", 32'(m1_rvalid), 32'd0);
    step(1'b0, NONE, rd(16'h0010));
    check("idle_no_gnt_yet", 32'(m1_gnt), 32'd0);
    step(1'b0, NONE, rd(16'h0010));
    check("idle_then_gnt",   32'(m1_gnt), 32'd1);

    // Simultaneous request from IDLE after an m0 burst.
    step(1'b1, NONE, NONE);
    repeat (4) step(1'b0, rd(16'h0060), NONE);
    step(1'b0, NONE, NONE);
    step(1'b0, rd(16'h0060), rd(16'h0070));
    check("tie_idle_none", 32'(m0_gnt || m1_gnt), 32'd0);
    step(1'b0, rd(16'h0060), rd(16'h0070));
`ifdef Z16_ARB_ROUND_ROBIN_EN
    check("tie_rr_m1", 32'(m1_gnt), 32'd1);
`else
    check("tie_fixed_m0", 32'(m0_gnt), 32'd1);
`endif

    // Randomized traffic with occasional resets, checked every cycle by the compare process.
    q0 = 1'b0;
    q1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(4) == 0) q0 = ~q0;
      if ($urandom_range(4) == 0) q1 = ~q1;
      step(($urandom_range(299) == 0), rnd_port(q0), rnd_port(q1));
    end

    checking = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z16_mem_arbiter.md
Z16_MEM_ARBITER -- requirements
Module: z16_mem_arbiter

Interface
REQ-001 SHALL have parameter P_MAX_BURST, default 8, meaning the maximum number of consecutive accepted beats per grant while the other master waits (range 1..15).
REQ-002 SHALL have port i_clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_m0_req / i_m1_req  input  1  access request from master 0 (CPU) / master 1 (loader).
REQ-005 SHALL have ports i_m0_wen / i_m1_wen  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports i_m0_addr / i_m1_addr  input  16  byte address.
REQ-007 SHALL have ports i_m0_wdata / i_m1_wdata  input  16  write data.
REQ-008 SHALL have ports o_m0_gnt / o_m1_gnt  output  1  registered grant.
REQ-009 SHALL have ports o_m0_rvalid / o_m1_rvalid  output  1  read-data valid pulse.
REQ-010 SHALL have ports o_m0_rdata / o_m1_rdata  output  16  registered read data.
REQ-011 SHALL have ports o_mem_addr  output  16, o_mem_wen  output  1, o_mem_wdata  output  16  single-port data-memory drive.
REQ-012 SHALL have port i_mem_rdata  input  16  combinational memory read data for o_mem_addr.

Function
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1; o_mX_gnt = 1 exactly when state is GNTX.
REQ-014 A beat SHALL be accepted in any cycle where i_mX_req && o_mX_gnt; o_mem_* then carry master X's fields.
REQ-015 o_mem_wen SHALL be 1 only on an accepted write beat; o_mem_addr/o_mem_wdata SHALL be 0 when no beat is accepted.
REQ-016 An accepted read SHALL capture i_mem_rdata into o_mX_rdata and pulse o_mX_rvalid for one cycle on the next cycle (latency 1); o_mX_rdata SHALL hold its value until the next read by the same master.
REQ-017 IDLE: if only one master requests -> GNT of that master next cycle; if both request -> priority per REQ-025/026; no request -> stay IDLE.
REQ-018 GNTX: if i_mX_req = 0 -> GNT of the other master if it requests, else IDLE.
REQ-019 GNTX SHALL keep a 4-bit beat counter, cleared on entering any GNT state and incremented per accepted beat.
REQ-020 GNTX: when the counter reaches P_MAX_BURST and the other master is requesting, the FSM SHALL switch to the other GNT state next cycle, regardless of i_mX_req.
REQ-021 When the other master is not requesting, the counter SHALL saturate at P_MAX_BURST and the grant SHALL be held.
REQ-022 A requester not granted SHALL be granted within P_MAX_BURST + 2 cycles of asserting req, provided it holds req.
REQ-023 Grants SHALL never be asserted to both masters in the same cycle; a switch SHALL pass through no idle cycle.
REQ-024 Request fields SHALL be sampled only on accepted beats; a master deasserting req while granted loses no data.

Reset
REQ-025 While i_rst = 1: state = IDLE, counter = 0, last-served = master 1, all o_* = 0; an in-flight read's rvalid SHALL be suppressed.

Configuration
REQ-026 Macro Z16_ARB_ROUND_ROBIN_EN defined: on simultaneous requests from IDLE, grant the master not served last (last-served register updated on each grant); undefined: master 0 always wins simultaneous requests, and no last-served register exists.

Verification
REQ-027 m0 write addr 0x0010 data 0xBEEF, then read 0x0010 -> o_mem_wen = 1 on write beat; o_m0_rvalid one cycle after read beat with o_m0_rdata = 0xBEEF.
REQ-028 Both masters request continuously from reset -> first grant m0 in both builds; with RR, m1 granted after exactly 8 m0 beats, then alternates every 8.
REQ-029 m1 requests continuously, m0 idle for 20 cycles -> o_m1_gnt held all 20 cycles, counter saturated at 8, no switch.
REQ-030 m1 granted, m0 asserts req mid-burst -> o_m0_gnt within 10 cycles; o_m0_gnt and o_m1_gnt never both 1.
REQ-031 Assert i_rst on the cycle after an accepted m1 read -> no o_m1_rvalid pulse; all outputs 0; FSM in IDLE.
REQ-032 Without Z16_ARB_ROUND_ROBIN_EN, both request from IDLE after an m0 burst -> m0 granted again.
